// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte stream and program-memory load port bundle
interface prog_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [11:0]       load_instr;
    logic              load_done;
    logic              load_err;

    // host / bench side: drives bytes, observes the load port
    modport master (
        output in_valid, in_data,
        input  in_ready, load_en, load_addr, load_instr, load_done, load_err
    );

    // loader side: consumes bytes, drives the load port
    modport slave (
        input  in_valid, in_data,
        output in_ready, load_en, load_addr, load_instr, load_done, load_err
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to program-memory loader with XOR checksum
module prog_loader #(
    parameter int          DEPTH     = 10,
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_SYNC, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic [3:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       instr_q, instr_d;
    logic              ready;
    logic              xfer;

    // byte-accepting states; ready is masked during reset so nothing transfers
    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_SYNC, S_COUNT, S_HI, S_LO, S_CSUM: ready = 1'b1;
            default:                             ready = 1'b0;
        endcase
    end

    assign xfer = bus.in_valid && ready;

    assign bus.in_ready   = ready && !rst;
    assign bus.load_en    = (state_q == S_WRITE);
    assign bus.load_addr  = addr_q;
    assign bus.load_instr = instr_q;
    assign bus.load_done  = (state_q == S_DONE);
    assign bus.load_err   = (state_q == S_ERR);

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
            n_q     <= '0;
            count_q <= '0;
            csum_q  <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // frame parser: next state plus count/checksum/address/instruction updates
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        csum_d  = csum_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            S_SYNC: begin
                if (xfer && bus.in_data == SYNC_BYTE) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) begin
                    if (bus.in_data == 8'd0 || bus.in_data > DEPTH_B) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = bus.in_data;
                        count_d = '0;
                        csum_d  = '0;
                        addr_d  = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    if (bus.in_data[7:4] != 4'd0) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = bus.in_data[3:0];
                        csum_d  = csum_q ^ bus.in_data;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    csum_d  = csum_q ^ bus.in_data;
                    instr_d = {hi_q, bus.in_data};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // address only advances when another word follows, so it never passes N-1
                count_d = count_q + 8'd1;
                if (count_d == n_q) begin
                    state_d = S_CSUM;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
            S_CSUM: begin
                if (xfer) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = state_q;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;
    logic clk;
    logic rst;

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.DEPTH(10), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           len;
        logic [127:0] data;
        int           nwr;
        logic [79:0]  wr;
        bit           exp_done;
        bit           exp_err;
        bit           stall;
    } vec_t;

    vec_t        vecs [7];
    logic [19:0] exp_q [$];
    logic [19:0] obs_q [$];
    int          rd_idx = 0;
    logic        prev_en   = 1'b0;
    logic        bad_pulse = 1'b0;
    logic        both_hi   = 1'b0;

    // monitor: record every write strobe, flag strobes wider than a cycle
    always @(negedge clk) begin
        if (bus.load_en) obs_q.push_back({bus.load_addr, bus.load_instr});
        if (bus.load_en && prev_en) bad_pulse <= 1'b1;
        if (bus.load_done && bus.load_err) both_hi <= 1'b1;
        prev_en <= bus.load_en;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int tries = 0;
        @(negedge clk);
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check("send_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_writes();
        logic [19:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin
                check("write", {12'd0, obs_q[rd_idx]}, {12'd0, e});
                rd_idx++;
            end else begin
                checks++;
                failures++;
                $display("FAIL write_missing got=none exp=%0h", e);
            end
        end
        check("extra_writes", 32'(obs_q.size() - rd_idx), 32'd0);
        rd_idx = obs_q.size();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load_en"}, {31'd0, bus.load_en}, 32'd0);
        check({tag, "_addr"},    {24'd0, bus.load_addr}, 32'd0);
        check({tag, "_instr"},   {20'd0, bus.load_instr}, 32'd0);
        check({tag, "_done"},    {31'd0, bus.load_done}, 32'd0);
        check({tag, "_err"},     {31'd0, bus.load_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check_idle("rst");
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic send_frame(input int v);
        for (int j = 0; j < vecs[v].nwr; j++)
            exp_q.push_back(vecs[v].wr[20*(vecs[v].nwr-1-j) +: 20]);
        for (int i = 0; i < vecs[v].len; i++)
            send_byte(vecs[v].data[8*(vecs[v].len-1-i) +: 8], vecs[v].stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hi, lo, cs;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{9, 128'({8'hA5, 8'h03, 8'h08, 8'h12, 8'h01, 8'hFF, 8'h00, 8'h07, 8'hE3}),
                    3, 80'({20'h00812, 20'h011FF, 20'h02007}), 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8, 128'({8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h0A, 8'hBC, 8'hB6}),
                    1, 80'(20'h00ABC), 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2, 128'({8'hA5, 8'h0B}), 0, 80'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2, 128'({8'hA5, 8'h00}), 0, 80'd0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3, 128'({8'hA5, 8'h02, 8'h18}), 0, 80'd0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{5, 128'({8'hA5, 8'h01, 8'h0A, 8'hBC, 8'h00}),
                    1, 80'(20'h00ABC), 1'b0, 1'b1, 1'b0};
        vecs[6] = vecs[0];
        vecs[6].stall = 1'b1;

        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            send_frame(v);
            repeat (3) @(negedge clk);
            check_writes();
            check($sformatf("v%0d_done", v), {31'd0, bus.load_done}, {31'd0, vecs[v].exp_done});
            check($sformatf("v%0d_err", v),  {31'd0, bus.load_err},  {31'd0, vecs[v].exp_err});
            check($sformatf("v%0d_ready", v), {31'd0, bus.in_ready}, 32'd0);
        end

        // full-depth frame: addresses 0..9
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h0A, 1'b0);
        cs = 8'h00;
        for (int j = 0; j < 10; j++) begin
            hi = 8'(j);
            lo = 8'(j * 13 + 5);
            cs = cs ^ hi ^ lo;
            exp_q.push_back({8'(j), hi[3:0], lo});
            send_byte(hi, 1'b0);
            send_byte(lo, 1'b0);
        end
        send_byte(cs, 1'b0);
        repeat (3) @(negedge clk);
        check_writes();
        check("max_done", {31'd0, bus.load_done}, 32'd1);
        check("max_err",  {31'd0, bus.load_err},  32'd0);

        // reset after two of three words, stalled, then a clean reload
        do_reset();
        exp_q.push_back(20'h00812);
        exp_q.push_back(20'h011FF);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        check_writes();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_nowrite", 32'(obs_q.size() - rd_idx), 32'd0);
        send_frame(6);
        repeat (3) @(negedge clk);
        check_writes();
        check("reload_done", {31'd0, bus.load_done}, 32'd1);
        check("reload_err",  {31'd0, bus.load_err},  32'd0);

        check("pulse_width", {31'd0, bad_pulse}, 32'd0);
        check("done_err_excl", {31'd0, both_hi}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
